// File: rtl/coupled_hold_cell.sv
// coupled_hold_cell
//   One cell of the Ising oscillator array. A phase wavefront on din is passed
//   to dout after one cycle, or held for |weight| extra cycles when the signed
//   coupling weight and the din/sout agreement call for it. A single-word
//   write/read slice carries weight, enable, spin preload and a saturating
//   hold-event counter.
//
// Ports
//   clk            clock for phase path and config path
//   ising_rstn     asynchronous active-low reset
//   din            previous stage, unrotated phase
//   sout           previous stage, rotated phase (coupling source)
//   dout           registered phase to next stage
//   wready         write strobe
//   wr_addr_match  this cell is addressed
//   wdata          write word: [W-1:0] weight, [8] enable, [9] stat_clear,
//                  [10] spin_load, [11] spin_val
//   rdata          read word:  [W-1:0] weight, [8] enable, [12] busy, [13] q,
//                  [16+CNT_W-1:16] hold_count, all other bits 0
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | q follows din (one-cycle pass), waiting for a wavefront to hold
// HOLD  | wavefront held, cnt counts remaining extra cycles down to 0
module coupled_hold_cell #(
    parameter int WEIGHT_W = 4,
    parameter int CNT_W    = 16
) (
    input  logic        clk,
    input  logic        ising_rstn,
    input  logic        din,
    input  logic        sout,
    output logic        dout,
    input  logic        wready,
    input  logic        wr_addr_match,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);

    localparam int CW = WEIGHT_W - 1;
    localparam logic [WEIGHT_W-1:0] W_MIN = WEIGHT_W'(1) << (WEIGHT_W - 1);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                      state_q, state_d;
    logic                        q_q, q_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [WEIGHT_W-1:0]         weight_q, weight_d;
    logic                        enable_q, enable_d;
    logic [CNT_W-1:0]            hold_count_q, hold_count_d;

    logic                        wr_en;
    logic                        stat_clear;
    logic                        spin_load;
    logic                        hold_inc;
    logic [WEIGHT_W-1:0]         wr_weight;
    logic [WEIGHT_W-1:0]         mag;
    logic                        w_pos;
    logic                        w_neg;
    logic                        wave;
    logic                        mis;
    logic                        hold_cond;
    logic                        unused_wdata;

    assign wr_en      = wready & wr_addr_match;
    assign stat_clear = wr_en & wdata[9];
    assign spin_load  = wr_en & wdata[10];
    assign unused_wdata = ^wdata;

    // The most negative code has no positive counterpart, so it is clamped
    // one step toward zero to keep |weight| within cnt's range.
    assign wr_weight = (wdata[WEIGHT_W-1:0] == W_MIN) ? (W_MIN | WEIGHT_W'(1))
                                                      : wdata[WEIGHT_W-1:0];

    assign w_neg = weight_q[WEIGHT_W-1];
    assign w_pos = ~weight_q[WEIGHT_W-1] & (|weight_q);
    assign mag   = w_neg ? (~weight_q + WEIGHT_W'(1)) : weight_q;

    assign wave      = din ^ q_q;
    assign mis       = din ^ sout;
    assign hold_cond = (w_pos & mis) | (w_neg & ~mis);

    always_comb begin
        weight_d = weight_q;
        enable_d = enable_q;
        if (wr_en) begin
            weight_d = wr_weight;
            enable_d = wdata[8];
        end
    end

    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        cnt_d    = cnt_q;
        hold_inc = 1'b0;
        if (spin_load) begin
            q_d     = wdata[11];
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!enable_q) begin
                        q_d = din;
                    end else if (wave && hold_cond && (mag != '0)) begin
                        state_d = HOLD;
                        cnt_d   = mag[CW-1:0] - CW'(1);
                    end else begin
                        q_d = din;
                    end
                end
                HOLD: begin
                    // Disabled or withdrawn wavefront: drop back without
                    // releasing and without counting an event.
                    if (!enable_q || !wave) begin
                        state_d = IDLE;
                    end else if (cnt_q == '0) begin
                        q_d      = din;
                        state_d  = IDLE;
                        hold_inc = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        hold_count_d = hold_count_q;
        if (stat_clear) begin
            hold_count_d = '0;
        end else if (hold_inc && !(&hold_count_q)) begin
            hold_count_d = hold_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge ising_rstn) begin
        if (!ising_rstn) begin
            state_q      <= IDLE;
            q_q          <= 1'b0;
            cnt_q        <= '0;
            weight_q     <= '0;
            enable_q     <= 1'b0;
            hold_count_q <= '0;
        end else begin
            state_q      <= state_d;
            q_q          <= q_d;
            cnt_q        <= cnt_d;
            weight_q     <= weight_d;
            enable_q     <= enable_d;
            hold_count_q <= hold_count_d;
        end
    end

    assign dout = q_q;

    always_comb begin
        rdata                  = '0;
        rdata[WEIGHT_W-1:0]    = weight_q;
        rdata[8]               = enable_q;
        rdata[12]              = (state_q == HOLD);
        rdata[13]              = q_q;
        rdata[16 +: CNT_W]     = hold_count_q;
    end

endmodule

// File: tb/tb_coupled_hold_cell.sv
`timescale 1ns/1ps
module tb_coupled_hold_cell;

    localparam int WW = 4;
    localparam int CW = 2;

    logic        clk;
    logic        ising_rstn;
    logic        din;
    logic        sout;
    logic        dout;
    logic        wready;
    logic        wr_addr_match;
    logic [31:0] wdata;
    logic [31:0] rdata;

    int checks = 0;
    int errors = 0;

    coupled_hold_cell #(.WEIGHT_W(WW), .CNT_W(CW)) dut (
        .clk           (clk),
        .ising_rstn    (ising_rstn),
        .din           (din),
        .sout          (sout),
        .dout          (dout),
        .wready        (wready),
        .wr_addr_match (wr_addr_match),
        .wdata         (wdata),
        .rdata         (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        dout;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];

    // Behavioural model: an outstanding hold is "how many more wave edges
    // must pass before the edge is released".
    bit m_q;
    bit m_holding;
    int m_left;
    int m_w;
    bit m_en;
    int m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_q = 0; m_holding = 0; m_left = 0; m_w = 0; m_en = 0; m_cnt = 0;
    endfunction

    function automatic int decode_weight(input logic [31:0] wd);
        int raw;
        raw = int'(wd[WW-1:0]);
        if (raw >= (1 << (WW - 1))) raw = raw - (1 << WW);
        if (raw == -(1 << (WW - 1))) raw = raw + 1;
        return raw;
    endfunction

    function automatic void model_step(input bit d, input bit s, input bit wr, input logic [31:0] wd);
        bit wave, mis, wants_hold, released;
        int mag;
        wave = (d != m_q);
        mis  = (d != s);
        mag  = (m_w < 0) ? -m_w : m_w;
        wants_hold = ((m_w > 0) && mis) || ((m_w < 0) && !mis);
        released = 0;
        if (wr && wd[10]) begin
            m_q = wd[11];
            m_holding = 0;
        end else if (!m_holding) begin
            if (m_en && wave && wants_hold && mag != 0) begin
                m_holding = 1;
                m_left = mag;
            end else begin
                m_q = d;
            end
        end else if (!m_en || !wave) begin
            m_holding = 0;
        end else begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_q = d;
                m_holding = 0;
                released = 1;
            end
        end
        if (wr && wd[9]) m_cnt = 0;
        else if (released && m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
        if (wr) begin
            m_en = wd[8];
            m_w  = decode_weight(wd);
        end
    endfunction

    function automatic logic [31:0] model_rdata();
        logic [31:0] r;
        r = '0;
        r[WW-1:0]   = m_w[WW-1:0];
        r[8]        = m_en;
        r[12]       = m_holding;
        r[13]       = m_q;
        r[16 +: CW] = m_cnt[CW-1:0];
        return r;
    endfunction

    function automatic logic [31:0] wd(input int w, input bit en, input bit clr = 0,
                                       input bit ld = 0, input bit sv = 0);
        logic [31:0] r;
        r = '0;
        r[WW-1:0] = w[WW-1:0];
        r[8]  = en;
        r[9]  = clr;
        r[10] = ld;
        r[11] = sv;
        return r;
    endfunction

    task automatic drive(input bit d, input bit s, input bit wr, input bit am, input logic [31:0] w);
        exp_t e;
        din = d; sout = s; wready = wr; wr_addr_match = am; wdata = w;
        model_step(d, s, wr & am, w);
        e.dout  = m_q;
        e.rdata = model_rdata();
        exp_q.push_back(e);
    endtask

    task automatic step(input bit d, input bit s, input bit wr = 0, input bit am = 0,
                        input logic [31:0] w = '0);
        @(negedge clk);
        #1;
        drive(d, s, wr, am, w);
    endtask

    task automatic write(input logic [31:0] w);
        step(din, sout, 1'b1, 1'b1, w);
    endtask

    // Present a wavefront that a positive weight will hold (sout != din).
    task automatic hold_edge_pos(input int cycles);
        bit d;
        d = ~m_q;
        for (int i = 0; i < cycles; i++) step(d, ~d);
    endtask

    // Monitor: compares every cycle the bench has a prediction for.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("dout", {31'd0, dout}, {31'd0, e.dout});
                chk("rdata", rdata, e.rdata);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit d;
        ising_rstn = 1'b0;
        din = 0; sout = 0; wready = 0; wr_addr_match = 0; wdata = '0;
        model_reset();
        #7;
        chk("reset_dout", {31'd0, dout}, 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        @(negedge clk);
        #1;
        ising_rstn = 1'b1;
        drive(0, 0, 0, 0, '0);

        // enable=0: one-cycle follow
        step(1, 0); step(0, 1); step(1, 1); step(0, 0);

        // weight +3, opposing sout -> held; agreeing sout -> pass
        write(wd(3, 1));
        step(0, 0);
        hold_edge_pos(5);
        d = ~m_q;
        step(d, d); step(d, d);

        // address mismatch must not write
        step(din, sout, 1, 0, wd(5, 0));

        // weight -2, agreeing sout -> held
        write(wd(-2, 1));
        d = ~m_q;
        step(d, d); step(d, d); step(d, d); step(d, d);

        // most negative code clamps
        write(wd(-8, 1));
        @(negedge clk);
        #1;
        chk("w_min_clamp", {28'd0, rdata[3:0]}, 32'd9);
        drive(din, sout, 0, 0, '0);

        // weight 5: withdrawal, then spin_load mid-hold
        write(wd(5, 1));
        hold_edge_pos(3);
        step(m_q, ~m_q); step(m_q, ~m_q);
        hold_edge_pos(2);
        d = din;
        step(d, ~d, 1, 1, wd(5, 1, 0, 1, ~m_q));
        step(d, ~d); step(d, ~d);

        // saturation and clear-wins
        write(wd(1, 1, 1));
        for (int i = 0; i < 4; i++) hold_edge_pos(2);
        @(negedge clk);
        #1;
        chk("hold_count_sat", {30'd0, rdata[17:16]}, 32'd3);
        drive(din, sout, 0, 0, '0);
        d = ~m_q;
        step(d, ~d);
        step(d, ~d, 1, 1, wd(1, 1, 1));
        @(negedge clk);
        #1;
        chk("clear_wins", {30'd0, rdata[17:16]}, 32'd0);
        drive(din, sout, 0, 0, '0);

        // weight change mid-hold
        write(wd(5, 1));
        d = ~m_q;
        step(d, ~d); step(d, ~d);
        step(d, ~d, 1, 1, wd(1, 1));
        for (int i = 0; i < 5; i++) step(d, ~d);
        hold_edge_pos(3);

        // enable cleared mid-hold
        write(wd(4, 1));
        d = ~m_q;
        step(d, ~d);
        step(d, ~d, 1, 1, wd(4, 0));
        step(d, ~d); step(~d, d);

        // async reset mid-hold
        write(wd(3, 1));
        hold_edge_pos(2);
        @(negedge clk);
        #3;
        ising_rstn = 1'b0;
        #1;
        chk("async_rst_dout", {31'd0, dout}, 32'd0);
        chk("async_rst_rdata", rdata, 32'd0);
        @(negedge clk);
        #1;
        ising_rstn = 1'b1;
        model_reset();
        drive(0, 0, 0, 0, '0);
        step(1, 0); step(0, 0); step(1, 1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit rd, rs, rw, ra;
            logic [31:0] w;
            rd = ($urandom_range(0, 3) == 0) ? din : ~din;
            if ($urandom_range(0, 1) == 0) rd = din;
            rs = $urandom_range(0, 1);
            rw = ($urandom_range(0, 9) == 0);
            ra = ($urandom_range(0, 7) != 0);
            w  = wd(int'($urandom_range(0, 15)), ($urandom_range(0, 9) != 0),
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
                    $urandom_range(0, 1));
            w[31:12] = $urandom;
            w[7:WW]  = $urandom;
            step(rd, rs, rw, ra, w);
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #2;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/coupled_hold_cell.md
# coupled_hold_cell

Parametrised, registered successor to the coupled counter cell for the Ising oscillator array. Each cell passes a phase wavefront from `din` to `dout`. Depending on a programmable signed weight and on the agreement between `din` and the rotated neighbour `sout`, the cell either passes the edge after one cycle or holds it for |weight| extra cycles. Configuration, spin preload and a saturating hold-event counter sit behind the same single-word AXI write/read slice used by the other cells. The cell is instantiated N×N in the array.

## Interface
- `WEIGHT_W`, 4: two's-complement weight width, legal range 2..8.
- `CNT_W`, 16: hold-event counter width, legal range 1..16.
- `clk`  in  1  single clock for the phase path and the config path.
- `ising_rstn`  in  1  reset, asynchronous, active-low.
- `din`  in  1  previous stage, unrotated phase.
- `sout`  in  1  previous stage, rotated phase (coupling source).
- `dout`  out  1  registered phase to next stage (`q`).
- `wready`  in  1  write strobe.
- `wr_addr_match`  in  1  this cell is addressed.
- `wdata`  in  32  write word:
  - [WEIGHT_W-1:0] weight
  - [8] enable
  - [9] stat_clear
  - [10] spin_load
  - [11] spin_val
- `rdata`  out  32  combinational from registers:
  - [WEIGHT_W-1:0] weight
  - [8] enable
  - [12] busy
  - [13] q
  - [16+CNT_W-1:16] hold_count
  - all other bits 0.

## Operation
- Write = `wready & wr_addr_match`. Each write loads weight and enable together.
  - A weight of -2^(WEIGHT_W-1) is stored as -(2^(WEIGHT_W-1)-1).
  - stat_clear and spin_load are one-shot pulses and are not stored.
- Derived signals:
  - mag = |weight|
  - wave = din ^ q
  - mis = din ^ sout
  - hold_cond = (weight>0 & mis) | (weight<0 & ~mis)
- FSM states: IDLE, HOLD. busy = (state==HOLD).
  - IDLE, enable=0: q <= din every cycle; state stays IDLE.
  - IDLE, wave & hold_cond & mag≠0: go to HOLD, cnt <= mag-1, q unchanged.
  - IDLE, wave otherwise: q <= din.
  - HOLD, ~wave: the wavefront was withdrawn. Go to IDLE; q unchanged; no stat increment.
  - HOLD, wave & cnt==0: q <= din; go to IDLE; hold_count++.
  - HOLD, wave & cnt≠0: cnt--.
- hold_cond is evaluated only on entry to HOLD.
  - Changes to `sout` during HOLD are ignored.
  - A weight write during HOLD does not alter cnt; the new weight applies from the next entry.
- spin_load write: q <= spin_val and state <= IDLE in the same cycle. This overrides every FSM action, including mid-HOLD.
- Clearing enable during HOLD forces IDLE on the next edge, and q then tracks din.
- hold_count saturates at 2^CNT_W-1. If a stat_clear write coincides with an increment, the clear wins and the result is 0.
- cnt width = WEIGHT_W-1 bits.

## Timing
- Reset (async assert, sync-to-clk deassert handled upstream):
  - q=0, so dout=0
  - state=IDLE, cnt=0
  - weight=0, enable=0
  - hold_count=0
  - rdata=0
- Pass latency: a din edge sampled at edge E1 appears on dout after E1 (1 cycle).
- Hold latency: a din edge sampled at E1 appears on dout after edge E(1+mag).
- Config write takes effect at the edge where the write is sampled. `rdata` reflects it after that edge.
- No combinational path from `din`/`sout` to `dout`.

## Test plan
- Reset mid-HOLD, with weight=3 and busy=1, assert `ising_rstn` -> immediately dout=0 and rdata=0; after release, din toggling with enable=0 shows 1-cycle follow.
- Weight=+3, enable=1, sout=~din, din 0→1 -> dout rises exactly 4 cycles after the sampling edge; busy high 3 cycles; hold_count=1. Same test with sout=din -> 1-cycle pass, hold_count unchanged.
- Weight=-2 written as 0b1110 with WEIGHT_W=4, din 0→1 with sout=1 -> 3-cycle latency; then write weight=0b1000 -> rdata weight reads 0b1001 (-7).
- HOLD entered with weight=5, then din returns to q after 2 cycles -> IDLE next edge, dout unchanged, hold_count unchanged; a later spin_load=1, spin_val=1 issued mid-HOLD -> dout=1 next edge, busy=0.
- CNT_W=2, 4 hold events -> hold_count saturates at 3. stat_clear issued in the same cycle as a completing hold -> hold_count reads 0.
- Weight write from +5 to +1 during an active hold with cnt=3 -> current hold still totals 6 cycles; the next hold totals 2 cycles.
